dct_prefft_chan_sched: RTL and testbench



---
 rtl/dct_prefft_chan_sched_pkg.sv | 14 +
 rtl/dct_prefft_chan_sched_if.sv | 23 ++
 rtl/dct_prefft_chan_sched_tag_fifo.sv | 61 ++++++
 rtl/dct_prefft_chan_sched.sv | 173 +++++++++++++++++
 tb/tb_dct_prefft_chan_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_prefft_chan_sched_pkg.sv
// Shared constants and types for the pre-FFT channel scheduler.
package dct_pkg;

  localparam int          FRAME_LEN_1200 = 1200;
  localparam logic [11:0] FFT_PTS        = 12'd2048;
  localparam int          BEAT_CNT_W     = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/dct_prefft_chan_sched_if.sv
// Reorder-sink bus: the scheduler is the master, the reorder stage the slave.
interface dct_prefft_chan_sched_if #(
  parameter int wDataInOut = 16
) ();

  logic                  ro_sink_valid;
  logic                  ro_sink_sop;
  logic                  ro_sink_eop;
  logic [wDataInOut-1:0] ro_sink_real;
  logic [wDataInOut-1:0] ro_sink_imag;
  logic                  ro_sink_ready;

  modport master (
    output ro_sink_valid, ro_sink_sop, ro_sink_eop, ro_sink_real, ro_sink_imag,
    input  ro_sink_ready
  );

  modport slave (
    input  ro_sink_valid, ro_sink_sop, ro_sink_eop, ro_sink_real, ro_sink_imag,
    output ro_sink_ready
  );

endinterface

// File: rtl/dct_prefft_chan_sched_tag_fifo.sv
// Channel-ID tag queue: one entry per frame handed to the reorder stage and
// not yet seen leaving it. Push when full and pop when empty are ignored.
module dct_sched_tag_fifo
  import dct_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic          wr_en;
  logic          rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (occ == OW'(DEPTH));
  assign empty = (occ == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  // Head is forced to zero when empty so tag_id reads 0 with no frame in flight.
  assign head  = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push/pop keeps occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/dct_prefft_chan_sched.sv
// Frame-level round-robin scheduler sharing one DCT pre-FFT reorder stage
// among NCH channels. Enforces the frame length and tags each frame with
// its source channel for the downstream consumer.
//
//   state | meaning
//   IDLE  | no frame open; pick next sop round-robin when sink and tag queue allow
//   XFER  | granted channel muxed onto reorder sink, beats counted
//   DROP  | overlong frame already closed on the sink; swallow beats up to ch_eop
module dct_prefft_chan_sched
  import dct_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int wDataInOut = 16,
  parameter int FRAME_LEN  = FRAME_LEN_1200,
  parameter int TAG_DEPTH  = 2,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            ch_valid,
  output logic [NCH-1:0]            ch_ready,
  input  logic [NCH-1:0]            ch_sop,
  input  logic [NCH-1:0]            ch_eop,
  input  logic [NCH*wDataInOut-1:0] ch_real,
  input  logic [NCH*wDataInOut-1:0] ch_imag,
  dct_prefft_chan_sched_if.master   sink,
  output logic [11:0]               ro_fftpts,
  input  logic                      ro_source_valid,
  input  logic                      ro_source_eop,
  output logic [CW-1:0]             tag_id,
  output logic                      tag_valid,
  output logic                      len_err,
  output logic [CW-1:0]             err_chan
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(FRAME_LEN - 1);

  sched_state_t          state;
  sched_state_t          next_state;
  logic [CW-1:0]         grant;
  logic [CW-1:0]         last_grant;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  last_beat;

  logic                  cand_found;
  logic [CW-1:0]         cand;
  logic [CW:0]           rr_sum;

  logic                  grant_en;
  logic                  beat_acc;
  logic                  tag_push;
  logic                  tag_pop;
  logic                  tag_full;
  logic                  tag_empty;
  logic                  len_err_set;

  assign ro_fftpts = FFT_PTS;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign tag_pop   = ro_source_valid & ro_source_eop;
  assign tag_valid = ~tag_empty;

  // Round-robin search for a channel offering sop, starting after last_grant;
  // iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    rr_sum     = '0;
    for (int i = NCH; i >= 1; i--) begin
      rr_sum = {1'b0, last_grant} + (CW+1)'(i);
      if (rr_sum >= (CW+1)'(NCH)) rr_sum = rr_sum - (CW+1)'(NCH);
      if (ch_valid[rr_sum[CW-1:0]] && ch_sop[rr_sum[CW-1:0]]) begin
        cand_found = 1'b1;
        cand       = rr_sum[CW-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state, channel handshakes and the combinational sink mux.
  always_comb begin
    next_state         = state;
    ch_ready           = '0;
    sink.ro_sink_valid = 1'b0;
    sink.ro_sink_sop   = 1'b0;
    sink.ro_sink_eop   = 1'b0;
    sink.ro_sink_real  = '0;
    sink.ro_sink_imag  = '0;
    grant_en           = 1'b0;
    beat_acc           = 1'b0;
    tag_push           = 1'b0;
    len_err_set        = 1'b0;
    case (state)
      IDLE: begin
        if (cand_found && sink.ro_sink_ready && !tag_full) begin
          grant_en   = 1'b1;
          next_state = XFER;
        end
      end
      XFER: begin
        ch_ready[grant]    = sink.ro_sink_ready;
        beat_acc           = ch_valid[grant] & sink.ro_sink_ready;
        sink.ro_sink_valid = beat_acc;
        // sop only on the first beat; eop forced when the frame hits full length
        sink.ro_sink_sop   = beat_acc & ch_sop[grant] & (beat_cnt == '0);
        sink.ro_sink_eop   = beat_acc & (ch_eop[grant] | last_beat);
        sink.ro_sink_real  = ch_real[grant*wDataInOut +: wDataInOut];
        sink.ro_sink_imag  = ch_imag[grant*wDataInOut +: wDataInOut];
        if (beat_acc) begin
          if (ch_eop[grant]) begin
            tag_push    = 1'b1;
            len_err_set = ~last_beat;
            next_state  = IDLE;
          end else if (last_beat) begin
            tag_push    = 1'b1;
            len_err_set = 1'b1;
            next_state  = DROP;
          end
        end
      end
      DROP: begin
        ch_ready[grant] = 1'b1;
        if (ch_valid[grant] && ch_eop[grant]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant register, round-robin pointer and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= CW'(NCH - 1);
      beat_cnt   <= '0;
    end else if (grant_en) begin
      grant      <= cand;
      last_grant <= cand;
      beat_cnt   <= '0;
    end else if (beat_acc) begin
      beat_cnt   <= beat_cnt + 1'b1;
    end
  end

  // Length-error pulse one cycle after the offending beat; channel held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err  <= 1'b0;
      err_chan <= '0;
    end else begin
      len_err <= len_err_set;
      if (len_err_set) err_chan <= grant;
    end
  end

  dct_sched_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (CW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (grant),
    .head  (tag_id),
    .full  (tag_full),
    .empty (tag_empty)
  );

endmodule

// File: tb/tb_dct_prefft_chan_sched.sv
// Directed bench for the pre-FFT channel scheduler. Sources emit frames whose
// real sample encodes {channel, beat index}, so the sink side can be checked
// beat by beat without peeking inside the design.
module tb_dct_prefft_chan_sched;

  localparam int NCH = 2;
  localparam int W   = 16;

  logic                clk;
  logic                rst_n;
  logic [NCH-1:0]      ch_valid, ch_ready, ch_sop, ch_eop;
  logic [NCH*W-1:0]    ch_real, ch_imag;
  logic [11:0]         ro_fftpts;
  logic                ro_source_valid, ro_source_eop;
  logic                tag_id, tag_valid, len_err, err_chan;

  dct_prefft_chan_sched_if #(.wDataInOut(W)) sink_if ();

  dct_prefft_chan_sched #(
    .NCH(NCH), .wDataInOut(W), .FRAME_LEN(1200), .TAG_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_sop(ch_sop), .ch_eop(ch_eop),
    .ch_real(ch_real), .ch_imag(ch_imag),
    .sink(sink_if.master),
    .ro_fftpts(ro_fftpts),
    .ro_source_valid(ro_source_valid), .ro_source_eop(ro_source_eop),
    .tag_id(tag_id), .tag_valid(tag_valid),
    .len_err(len_err), .err_chan(err_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_pass;
  int cyc;
  int src_len [NCH];
  int src_idx [NCH];
  int src_frames [NCH];
  int first_acc [NCH];
  int eop_acc [NCH];
  int fwd_beats, frm_beat, cur_ch, sop_bad, data_bad, drop_cnt, lerr_cnt, lerr_cyc, pop_n;
  int eop_q[$];
  int grant_q[$];
  logic auto_pop, pop_req;
  logic [NCH-1:0] last_ready;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    fwd_beats = 0; frm_beat = 0; cur_ch = 0; sop_bad = 0; data_bad = 0;
    drop_cnt = 0; lerr_cnt = 0; lerr_cyc = -1; pop_n = 0;
    eop_q.delete(); grant_q.delete();
    auto_pop = 1'b0; pop_req = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      first_acc[c] = -1; eop_acc[c] = -1;
      src_len[c] = 1200; src_idx[c] = 0; src_frames[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_valid = '0; ch_sop = '0; ch_eop = '0; ch_real = '0; ch_imag = '0;
    ro_source_valid = 1'b0; ro_source_eop = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // One clock: drive sources, sample outputs mid-cycle, advance on the edge.
  task automatic cycle();
    logic [W-1:0]   r;
    logic [NCH-1:0] acc;
    logic           do_pop;
    int             bch, bidx;
    for (int c = 0; c < NCH; c++) begin
      if (src_frames[c] > 0) begin
        ch_valid[c] = 1'b1;
        ch_sop[c]   = (src_idx[c] == 0);
        ch_eop[c]   = (src_idx[c] == src_len[c] - 1);
        ch_real[c*W +: W] = W'(c*4096 + src_idx[c]);
        ch_imag[c*W +: W] = ~W'(c*4096 + src_idx[c]);
      end else begin
        ch_valid[c] = 1'b0; ch_sop[c] = 1'b0; ch_eop[c] = 1'b0;
        ch_real[c*W +: W] = '0; ch_imag[c*W +: W] = '0;
      end
    end
    do_pop = (auto_pop && tag_valid) || pop_req;
    pop_req = 1'b0;
    ro_source_valid = do_pop;
    ro_source_eop   = do_pop;
    #1;
    last_ready = ch_ready;
    if (auto_pop && tag_valid) begin
      chk("pop_tag_order", tag_id, pop_n % 2);
      pop_n++;
    end
    if (sink_if.ro_sink_valid) begin
      r    = sink_if.ro_sink_real;
      bch  = int'(r[15:12]);
      bidx = int'(r[11:0]);
      if (frm_beat == 0) begin
        grant_q.push_back(bch);
        cur_ch = bch;
        if (!sink_if.ro_sink_sop) sop_bad++;
      end else if (sink_if.ro_sink_sop) sop_bad++;
      if (bch != cur_ch || bidx != frm_beat || sink_if.ro_sink_imag != ~r) data_bad++;
      fwd_beats++;
      if (sink_if.ro_sink_eop) begin
        eop_q.push_back(frm_beat);
        frm_beat = 0;
      end else frm_beat++;
    end
    if (len_err) begin lerr_cnt++; lerr_cyc = cyc; end
    acc = ch_valid & ch_ready;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        if (first_acc[c] < 0) first_acc[c] = cyc;
        if (ch_eop[c]) eop_acc[c] = cyc;
        if (!sink_if.ro_sink_valid) drop_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    ro_source_valid = 1'b0;
    ro_source_eop   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        src_idx[c]++;
        if (src_idx[c] == src_len[c]) begin
          src_idx[c] = 0;
          src_frames[c]--;
        end
      end
    end
  endtask

  task automatic run_frames(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && (src_frames[0] + src_frames[1]) > 0) begin
      cycle();
      n++;
    end
    chk(tag, n < budget, 1);
    repeat (3) cycle();
  endtask

  initial begin
    int n;
    n_checks = 0; n_pass = 0; cyc = 0;
    sink_if.ro_sink_ready = 1'b1;
    rst_n = 1'b0;
    ch_valid = '0; ch_sop = '0; ch_eop = '0; ch_real = '0; ch_imag = '0;
    ro_source_valid = 1'b0; ro_source_eop = 1'b0;
    clear_mon();
    #13;
    chk("rst_fftpts", ro_fftpts, 2048);
    chk("rst_sink_valid", sink_if.ro_sink_valid, 0);
    chk("rst_sink_eop", sink_if.ro_sink_eop, 0);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_tag_valid", tag_valid, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_err_chan", err_chan, 0);

    // Single legal frame from channel 0.
    do_reset();
    src_frames[0] = 1;
    run_frames("t1_timeout", 1400);
    chk("t1_fwd_beats", fwd_beats, 1200);
    chk("t1_sop_bad", sop_bad, 0);
    chk("t1_data_bad", data_bad, 0);
    chk("t1_eop_pos", eop_q.size() > 0 ? eop_q[0] : -1, 1199);
    chk("t1_grant_lat", first_acc[0], 1);
    chk("t1_len_err", lerr_cnt, 0);
    chk("t1_tag_valid", tag_valid, 1);
    chk("t1_tag_id", tag_id, 0);
    pop_req = 1'b1;
    cycle();
    chk("t1_tag_popped", tag_valid, 0);

    // Both channels, four frames each, tags popped as they appear.
    do_reset();
    src_frames[0] = 4; src_frames[1] = 4;
    auto_pop = 1'b1;
    run_frames("t2_timeout", 10000);
    chk("t2_frames", grant_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_grant_order", grant_q.size() > i ? grant_q[i] : -1, i % 2);
    chk("t2_pops", pop_n, 8);
    chk("t2_fwd_beats", fwd_beats, 9600);
    chk("t2_data_bad", data_bad, 0);

    // Short frame: channel 1 ends at beat 999.
    do_reset();
    src_frames[1] = 1; src_len[1] = 1000;
    run_frames("t3_timeout", 1200);
    chk("t3_fwd_beats", fwd_beats, 1000);
    chk("t3_eop_pos", eop_q.size() > 0 ? eop_q[0] : -1, 999);
    chk("t3_len_err_cnt", lerr_cnt, 1);
    chk("t3_len_err_cyc", lerr_cyc, 1001);
    chk("t3_err_chan", err_chan, 1);
    chk("t3_tag_valid", tag_valid, 1);
    chk("t3_tag_id", tag_id, 1);

    // Overlong frame on channel 0 while channel 1 waits.
    do_reset();
    src_frames[0] = 1; src_len[0] = 1300;
    src_frames[1] = 1;
    auto_pop = 1'b1;
    run_frames("t4_timeout", 3000);
    chk("t4_fwd_beats", fwd_beats, 2400);
    chk("t4_forced_eop", eop_q.size() > 0 ? eop_q[0] : -1, 1199);
    chk("t4_dropped", drop_cnt, 100);
    chk("t4_len_err_cnt", lerr_cnt, 1);
    chk("t4_len_err_cyc", lerr_cyc, 1201);
    chk("t4_next_grant", first_acc[1], eop_acc[0] + 2);
    chk("t4_ch1_eop", eop_q.size() > 1 ? eop_q[1] : -1, 1199);
    chk("t4_err_chan", err_chan, 0);

    // Tag queue full blocks the third grant until one pop.
    do_reset();
    src_frames[0] = 2; src_frames[1] = 1;
    repeat (2450) cycle();
    chk("t5_fwd_blocked", fwd_beats, 2400);
    chk("t5_ready_blocked", last_ready, 0);
    chk("t5_head", tag_id, 0);
    pop_req = 1'b1;
    cycle();
    chk("t5_head_after_pop", tag_id, 1);
    cycle();
    chk("t5_grant_cycle_idle", last_ready, 0);
    cycle();
    chk("t5_xfer_ready", last_ready, 1);
    run_frames("t5_timeout", 1300);
    chk("t5_fwd_total", fwd_beats, 3600);
    chk("t5_third_grant", grant_q.size() > 2 ? grant_q[2] : -1, 0);

    // Reset in the middle of a frame.
    do_reset();
    src_frames[0] = 2;
    n = 0;
    while (fwd_beats < 1700 && n < 3000) begin cycle(); n++; end
    chk("t6_reach_beat", fwd_beats, 1700);
    chk("t6_tag_before", tag_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_sink_valid", sink_if.ro_sink_valid, 0);
    chk("t6_ch_ready", ch_ready, 0);
    chk("t6_tag_valid", tag_valid, 0);
    do_reset();
    src_frames[0] = 1;
    run_frames("t6_timeout", 1400);
    chk("t6_fwd_beats", fwd_beats, 1200);
    chk("t6_grant_lat", first_acc[0], 1);
    chk("t6_tag_id", tag_id, 0);
    chk("t6_tag_valid2", tag_valid, 1);
    chk("t6_len_err", lerr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
